axis_byte_bridge: RTL and testbench

- Host-side counterpart of the network processor's packet stream interface.
- Assembles an 8-bit AXI-Stream byte stream (from UART/host RX) into INP_WIDTH-wide source packets for the processor's AXI-Stream slave.
- Serializes OUT_WIDTH-wide sink packets from the processor's AXI-Stream master into an 8-bit byte stream (to host TX).
- Both directions are independent, full-throughput (one byte per cycle sustained) and big-endian on the wire (MSB byte first).

---
 rtl/axis_byte_bridge_pkg.sv | 21 ++
 rtl/axis_pkt_serializer.sv | 50 +++++
 rtl/axis_byte_bridge.sv | 96 +++++++++
 tb/tb_axis_byte_bridge.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_byte_bridge_pkg.sv
// Shared configuration for the byte-stream bridge: byte width and sizing helpers.
package bridge_config;

    localparam int BYTE_WIDTH = 8;

    // Number of whole bytes in a packet of the given bit width.
    function automatic int bytes_of(input int width);
        return width / BYTE_WIDTH;
    endfunction

    // Counter width able to index n states, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // True when a packet width is a non-zero whole number of bytes.
    function automatic bit width_ok(input int width);
        return (width > 0) && ((width % BYTE_WIDTH) == 0);
    endfunction

endpackage

// File: rtl/axis_pkt_serializer.sv
// Splits PKT_WIDTH-wide AXI-Stream packets into a big-endian byte stream.
// A new packet loads on the same edge the last byte leaves, so output is gapless.
module axis_pkt_serializer
    import bridge_config::*;
#(
    parameter int PKT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic [PKT_WIDTH-1:0] s_pkt_tdata,
    input  logic                 s_pkt_tvalid,
    output logic                 s_pkt_tready,
    output logic [7:0]           m_byte_tdata,
    output logic                 m_byte_tvalid,
    input  logic                 m_byte_tready
);

    localparam int NB = bytes_of(PKT_WIDTH);
    // Remaining count runs 0..NB inclusive, hence NB+1 states.
    localparam int RW = cnt_width(NB + 1);
    localparam logic [RW-1:0] NB_CNT = RW'(NB);

    logic [PKT_WIDTH-1:0] r_sr;
    logic [RW-1:0]        r_rem;
    logic                 w_load;
    logic                 w_shift;

    assign m_byte_tvalid = (r_rem != '0);
    assign m_byte_tdata  = r_sr[PKT_WIDTH-1 -: BYTE_WIDTH];
    assign s_pkt_tready  = (r_rem == '0) || ((r_rem == RW'(1)) && m_byte_tready);
    assign w_load        = s_pkt_tvalid && s_pkt_tready;
    assign w_shift       = m_byte_tvalid && m_byte_tready;

    // Load a new packet (priority) or shift out the byte just transferred.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sr  <= '0;
            r_rem <= '0;
        end else if (w_load) begin
            r_sr  <= s_pkt_tdata;
            r_rem <= NB_CNT;
        end else if (w_shift) begin
            r_sr  <= r_sr << BYTE_WIDTH;
            r_rem <= r_rem - RW'(1);
        end
    end

endmodule

// File: rtl/axis_byte_bridge.sv
// Host-side bridge: assembles RX bytes into INP_WIDTH packets and serializes
// OUT_WIDTH packets into TX bytes. Both directions are big-endian on the wire.
module axis_byte_bridge
    import bridge_config::*;
#(
    parameter int INP_WIDTH = 16,
    parameter int OUT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic [7:0]           s_byte_tdata,
    input  logic                 s_byte_tvalid,
    output logic                 s_byte_tready,
    output logic [INP_WIDTH-1:0] m_pkt_tdata,
    output logic                 m_pkt_tvalid,
    input  logic                 m_pkt_tready,
    input  logic [OUT_WIDTH-1:0] s_pkt_tdata,
    input  logic                 s_pkt_tvalid,
    output logic                 s_pkt_tready,
    output logic [7:0]           m_byte_tdata,
    output logic                 m_byte_tvalid,
    input  logic                 m_byte_tready
);

    if (!width_ok(INP_WIDTH) || !width_ok(OUT_WIDTH)) begin : g_bad_width
        $error("axis_byte_bridge: INP_WIDTH and OUT_WIDTH must be non-zero multiples of 8");
    end

    localparam int NBI   = bytes_of(INP_WIDTH);
    localparam int RX_CW = cnt_width(NBI);
    localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(NBI - 1);

    logic [INP_WIDTH-1:0] r_asm;
    logic [RX_CW-1:0]     r_rx_cnt;
    logic [INP_WIDTH-1:0] r_pkt_data;
    logic                 r_pkt_valid;

    logic                 w_final;
    logic                 w_byte_acc;
    logic                 w_pkt_xfer;
    logic [INP_WIDTH-1:0] w_asm_next;

    // The final byte may only land when the output slot is free or draining;
    // earlier bytes go into the assembly register regardless of backpressure.
    assign w_final       = (r_rx_cnt == RX_LAST);
    assign s_byte_tready = !w_final || !r_pkt_valid || m_pkt_tready;
    assign w_byte_acc    = s_byte_tvalid && s_byte_tready;
    assign w_pkt_xfer    = r_pkt_valid && m_pkt_tready;
    assign w_asm_next    = (r_asm << BYTE_WIDTH) | INP_WIDTH'(s_byte_tdata);

    assign m_pkt_tdata   = r_pkt_data;
    assign m_pkt_tvalid  = r_pkt_valid;

    // Shift accepted bytes into the assembly register and track position.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_asm    <= '0;
            r_rx_cnt <= '0;
        end else if (w_byte_acc) begin
            if (w_final) begin
                r_rx_cnt <= '0;
            end else begin
                r_asm    <= w_asm_next;
                r_rx_cnt <= r_rx_cnt + RX_CW'(1);
            end
        end
    end

    // Output packet register: a completing packet replaces (or refills) it,
    // otherwise a downstream transfer empties it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_pkt_data  <= '0;
            r_pkt_valid <= 1'b0;
        end else if (w_byte_acc && w_final) begin
            r_pkt_data  <= w_asm_next;
            r_pkt_valid <= 1'b1;
        end else if (w_pkt_xfer) begin
            r_pkt_valid <= 1'b0;
        end
    end

    axis_pkt_serializer #(
        .PKT_WIDTH (OUT_WIDTH)
    ) u_tx (
        .clk           (clk),
        .arstn         (arstn),
        .s_pkt_tdata   (s_pkt_tdata),
        .s_pkt_tvalid  (s_pkt_tvalid),
        .s_pkt_tready  (s_pkt_tready),
        .m_byte_tdata  (m_byte_tdata),
        .m_byte_tvalid (m_byte_tvalid),
        .m_byte_tready (m_byte_tready)
    );

endmodule

// File: tb/tb_axis_byte_bridge.sv
// Scoreboard bench for axis_byte_bridge: a 16/24-bit instance and an 8/8 instance.
module tb_axis_byte_bridge;

    logic clk = 1'b0;
    logic arstn = 1'b0;

    // Instance A: INP_WIDTH=16, OUT_WIDTH=24
    logic [7:0]  s_byte_tdata = '0;
    logic        s_byte_tvalid = 1'b0;
    logic        s_byte_tready;
    logic [15:0] m_pkt_tdata;
    logic        m_pkt_tvalid;
    logic        m_pkt_tready = 1'b0;
    logic [23:0] s_pkt_tdata = '0;
    logic        s_pkt_tvalid = 1'b0;
    logic        s_pkt_tready;
    logic [7:0]  m_byte_tdata;
    logic        m_byte_tvalid;
    logic        m_byte_tready = 1'b0;

    // Instance B: INP_WIDTH=8, OUT_WIDTH=8
    logic [7:0] b_s_byte_tdata = '0;
    logic       b_s_byte_tvalid = 1'b0;
    logic       b_s_byte_tready;
    logic [7:0] b_m_pkt_tdata;
    logic       b_m_pkt_tvalid;
    logic       b_m_pkt_tready = 1'b0;
    logic [7:0] b_s_pkt_tdata = '0;
    logic       b_s_pkt_tvalid = 1'b0;
    logic       b_s_pkt_tready;
    logic [7:0] b_m_byte_tdata;
    logic       b_m_byte_tvalid;
    logic       b_m_byte_tready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_pkt[$];
    logic [7:0]  exp_byte[$];
    logic [7:0]  exp_pkt_b[$];
    logic [7:0]  exp_byte_b[$];

    always #5 clk = ~clk;

    axis_byte_bridge #(.INP_WIDTH(16), .OUT_WIDTH(24)) u_dut (
        .clk           (clk),
        .arstn         (arstn),
        .s_byte_tdata  (s_byte_tdata),
        .s_byte_tvalid (s_byte_tvalid),
        .s_byte_tready (s_byte_tready),
        .m_pkt_tdata   (m_pkt_tdata),
        .m_pkt_tvalid  (m_pkt_tvalid),
        .m_pkt_tready  (m_pkt_tready),
        .s_pkt_tdata   (s_pkt_tdata),
        .s_pkt_tvalid  (s_pkt_tvalid),
        .s_pkt_tready  (s_pkt_tready),
        .m_byte_tdata  (m_byte_tdata),
        .m_byte_tvalid (m_byte_tvalid),
        .m_byte_tready (m_byte_tready)
    );

    axis_byte_bridge #(.INP_WIDTH(8), .OUT_WIDTH(8)) u_dut8 (
        .clk           (clk),
        .arstn         (arstn),
        .s_byte_tdata  (b_s_byte_tdata),
        .s_byte_tvalid (b_s_byte_tvalid),
        .s_byte_tready (b_s_byte_tready),
        .m_pkt_tdata   (b_m_pkt_tdata),
        .m_pkt_tvalid  (b_m_pkt_tvalid),
        .m_pkt_tready  (b_m_pkt_tready),
        .s_pkt_tdata   (b_s_pkt_tdata),
        .s_pkt_tvalid  (b_s_pkt_tvalid),
        .s_pkt_tready  (b_s_pkt_tready),
        .m_byte_tdata  (b_m_byte_tdata),
        .m_byte_tvalid (b_m_byte_tvalid),
        .m_byte_tready (b_m_byte_tready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and direct probes happen 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a transfer is about to happen at the next rising edge whenever
    // valid && ready are both high at the falling edge.
    always @(negedge clk) begin
        if (arstn && m_pkt_tvalid && m_pkt_tready) begin
            if (exp_pkt.size() == 0) check("a_pkt_unexpected", 32'(m_pkt_tdata), 32'hDEAD);
            else check("a_pkt_data", 32'(m_pkt_tdata), 32'(exp_pkt.pop_front()));
        end
        if (arstn && m_byte_tvalid && m_byte_tready) begin
            if (exp_byte.size() == 0) check("a_byte_unexpected", 32'(m_byte_tdata), 32'hDEAD);
            else check("a_byte_data", 32'(m_byte_tdata), 32'(exp_byte.pop_front()));
        end
        if (arstn && b_m_pkt_tvalid && b_m_pkt_tready) begin
            if (exp_pkt_b.size() == 0) check("b_pkt_unexpected", 32'(b_m_pkt_tdata), 32'hDEAD);
            else check("b_pkt_data", 32'(b_m_pkt_tdata), 32'(exp_pkt_b.pop_front()));
        end
        if (arstn && b_m_byte_tvalid && b_m_byte_tready) begin
            if (exp_byte_b.size() == 0) check("b_byte_unexpected", 32'(b_m_byte_tdata), 32'hDEAD);
            else check("b_byte_data", 32'(b_m_byte_tdata), 32'(exp_byte_b.pop_front()));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("rst_pkt_valid", 32'(m_pkt_tvalid), 0);
        check("rst_byte_valid", 32'(m_byte_tvalid), 0);
        check("rst_pkt_data", 32'(m_pkt_tdata), 0);
        check("rst_byte_data", 32'(m_byte_tdata), 0);
        check("rst_s_pkt_ready", 32'(s_pkt_tready), 1);
        check("rst_s_byte_ready", 32'(s_byte_tready), 1);
        tick();
        arstn = 1'b1;
        tick();

        // ---------------- RX basic ----------------
        m_pkt_tready = 1'b1;
        exp_pkt.push_back(16'hA53C);
        s_byte_tdata = 8'hA5; s_byte_tvalid = 1'b1;
        check("rxb_ready0", 32'(s_byte_tready), 1);
        tick();
        check("rxb_valid_early", 32'(m_pkt_tvalid), 0);
        s_byte_tdata = 8'h3C;
        tick();
        s_byte_tvalid = 1'b0;
        check("rxb_valid_lat", 32'(m_pkt_tvalid), 1);
        check("rxb_data", 32'(m_pkt_tdata), 32'hA53C);
        tick();
        check("rxb_valid_drop", 32'(m_pkt_tvalid), 0);

        // ---------------- RX backpressure ----------------
        m_pkt_tready = 1'b0;
        exp_pkt.push_back(16'h1122);
        exp_pkt.push_back(16'h3344);
        s_byte_tdata = 8'h11; s_byte_tvalid = 1'b1;
        tick();
        s_byte_tdata = 8'h22;
        check("rxp_final_free", 32'(s_byte_tready), 1);
        tick();
        s_byte_tdata = 8'h33;
        check("rxp_nonfinal_rdy", 32'(s_byte_tready), 1);
        check("rxp_held_valid", 32'(m_pkt_tvalid), 1);
        tick();
        s_byte_tdata = 8'h44;
        check("rxp_final_stall", 32'(s_byte_tready), 0);
        check("rxp_held_data", 32'(m_pkt_tdata), 32'h1122);
        tick();
        check("rxp_still_stall", 32'(s_byte_tready), 0);
        check("rxp_still_data", 32'(m_pkt_tdata), 32'h1122);
        m_pkt_tready = 1'b1;
        #1;
        check("rxp_release_rdy", 32'(s_byte_tready), 1);
        tick();
        s_byte_tvalid = 1'b0;
        check("rxp_nogap_valid", 32'(m_pkt_tvalid), 1);
        check("rxp_nogap_data", 32'(m_pkt_tdata), 32'h3344);
        tick();
        check("rxp_drained", 32'(m_pkt_tvalid), 0);

        // ---------------- TX basic ----------------
        m_byte_tready = 1'b1;
        exp_byte.push_back(8'h12); exp_byte.push_back(8'h34); exp_byte.push_back(8'h56);
        s_pkt_tdata = 24'h123456; s_pkt_tvalid = 1'b1;
        check("txb_idle_rdy", 32'(s_pkt_tready), 1);
        tick();
        s_pkt_tvalid = 1'b0;
        check("txb_b0_valid", 32'(m_byte_tvalid), 1);
        check("txb_b0", 32'(m_byte_tdata), 32'h12);
        check("txb_busy", 32'(s_pkt_tready), 0);
        tick();
        check("txb_b1", 32'(m_byte_tdata), 32'h34);
        tick();
        check("txb_b2", 32'(m_byte_tdata), 32'h56);
        check("txb_rdy_last", 32'(s_pkt_tready), 1);
        tick();
        check("txb_idle", 32'(m_byte_tvalid), 0);

        // ---------------- TX back-to-back + stall ----------------
        exp_byte.push_back(8'hAB); exp_byte.push_back(8'hCD); exp_byte.push_back(8'hEF);
        exp_byte.push_back(8'h01); exp_byte.push_back(8'h02); exp_byte.push_back(8'h03);
        s_pkt_tdata = 24'hABCDEF; s_pkt_tvalid = 1'b1;
        tick();
        s_pkt_tdata = 24'h010203;
        check("tx2_b0", 32'(m_byte_tdata), 32'hAB);
        tick();
        m_byte_tready = 1'b0;
        check("tx2_b1", 32'(m_byte_tdata), 32'hCD);
        tick();
        check("tx2_stall_data", 32'(m_byte_tdata), 32'hCD);
        check("tx2_stall_valid", 32'(m_byte_tvalid), 1);
        check("tx2_stall_nordy", 32'(s_pkt_tready), 0);
        m_byte_tready = 1'b1;
        tick();
        check("tx2_b2", 32'(m_byte_tdata), 32'hEF);
        check("tx2_rdy_last", 32'(s_pkt_tready), 1);
        tick();
        s_pkt_tvalid = 1'b0;
        check("tx2_nogap_valid", 32'(m_byte_tvalid), 1);
        check("tx2_nogap_data", 32'(m_byte_tdata), 32'h01);
        tick();
        check("tx2_b4", 32'(m_byte_tdata), 32'h02);
        tick();
        check("tx2_b5", 32'(m_byte_tdata), 32'h03);
        tick();
        check("tx2_idle", 32'(m_byte_tvalid), 0);

        // ---------------- reset mid-operation ----------------
        m_byte_tready = 1'b0;
        s_byte_tdata = 8'hA5; s_byte_tvalid = 1'b1;
        s_pkt_tdata = 24'h123456; s_pkt_tvalid = 1'b1;
        tick();
        s_byte_tvalid = 1'b0; s_pkt_tvalid = 1'b0;
        check("rstm_tx_busy", 32'(m_byte_tdata), 32'h12);
        #2;
        arstn = 1'b0;
        #1;
        check("rstm_byte_valid", 32'(m_byte_tvalid), 0);
        check("rstm_byte_data", 32'(m_byte_tdata), 0);
        check("rstm_pkt_valid", 32'(m_pkt_tvalid), 0);
        tick();
        arstn = 1'b1;
        m_byte_tready = 1'b1;
        exp_pkt.push_back(16'h7788);
        s_byte_tdata = 8'h77; s_byte_tvalid = 1'b1;
        tick();
        check("rstm_no_tx", 32'(m_byte_tvalid), 0);
        s_byte_tdata = 8'h88;
        tick();
        s_byte_tvalid = 1'b0;
        check("rstm_rx_valid", 32'(m_pkt_tvalid), 1);
        check("rstm_rx_data", 32'(m_pkt_tdata), 32'h7788);
        tick();
        check("rstm_no_tx2", 32'(m_byte_tvalid), 0);

        // ---------------- width edge: 8/8 instance ----------------
        b_m_pkt_tready = 1'b1; b_m_byte_tready = 1'b1;
        exp_pkt_b.push_back(8'h5A);  exp_pkt_b.push_back(8'hC3);
        exp_byte_b.push_back(8'h5A); exp_byte_b.push_back(8'hC3);
        b_s_byte_tdata = 8'h5A; b_s_byte_tvalid = 1'b1;
        b_s_pkt_tdata  = 8'h5A; b_s_pkt_tvalid  = 1'b1;
        check("w8_byte_rdy", 32'(b_s_byte_tready), 1);
        check("w8_pkt_rdy", 32'(b_s_pkt_tready), 1);
        tick();
        b_s_byte_tdata = 8'hC3; b_s_pkt_tdata = 8'hC3;
        check("w8_rx_valid", 32'(b_m_pkt_tvalid), 1);
        check("w8_rx_data", 32'(b_m_pkt_tdata), 32'h5A);
        check("w8_tx_valid", 32'(b_m_byte_tvalid), 1);
        check("w8_tx_data", 32'(b_m_byte_tdata), 32'h5A);
        check("w8_byte_rdy_full", 32'(b_s_byte_tready), 1);
        check("w8_pkt_rdy_full", 32'(b_s_pkt_tready), 1);
        tick();
        b_s_byte_tvalid = 1'b0; b_s_pkt_tvalid = 1'b0;
        check("w8_rx_data2", 32'(b_m_pkt_tdata), 32'hC3);
        check("w8_tx_data2", 32'(b_m_byte_tdata), 32'hC3);
        tick();
        check("w8_rx_idle", 32'(b_m_pkt_tvalid), 0);
        check("w8_tx_idle", 32'(b_m_byte_tvalid), 0);

        // ---------------- scoreboards drained ----------------
        tick();
        check("sb_a_pkt_empty", 32'(exp_pkt.size()), 0);
        check("sb_a_byte_empty", 32'(exp_byte.size()), 32'd0);
        check("sb_b_pkt_empty", 32'(exp_pkt_b.size()), 0);
        check("sb_b_byte_empty", 32'(exp_byte_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
